ranged_dual_counter: RTL and testbench

//  Parametrised successor of the dual integer/unsigned counter block, used as a

---
 rtl/ranged_dual_counter.sv | 127 ++++++++++++
 tb/tb_ranged_dual_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ranged_dual_counter.sv
// ranged_dual_counter
//   Two independent count channels that share one set of controls:
//     - an unsigned channel confined to [0 .. U_MAX]
//     - a two's-complement signed channel confined to [S_MIN .. S_MAX]
//   Each channel counts up or down, loads a clamped value, clears, and either
//   wraps or saturates at its bounds. A registered terminal-count pulse marks
//   every enabled step attempted from a bound.
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous, active-low reset
//     en        step enable
//     up        step direction (1 = up, 0 = down), used only when en = 1
//     clear     synchronous clear of both channels (highest priority)
//     load      synchronous load of both channels from load_val
//     load_val  load value; unsigned view for u, signed view for s
//     u_count   unsigned channel value
//     s_count   signed channel value (two's complement)
//     u_tc      unsigned terminal-count pulse
//     s_tc      signed terminal-count pulse
//
//   Control priority on each edge: clear > load > en step > hold.
//   All outputs are registered; no combinational input-to-output path.
module ranged_dual_counter #(
   parameter int WIDTH    = 5,
   parameter int U_MAX    = 10,
   parameter int S_MIN    = -10,
   parameter int S_MAX    = 10,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] u_count,
   output logic [WIDTH-1:0] s_count,
   output logic             u_tc,
   output logic             s_tc
);

   // Bounds must be representable in WIDTH bits so that no step can ever
   // overflow the register; reject bad parameter sets at elaboration.
   if (U_MAX < 0 || U_MAX > (2**WIDTH) - 1 ||
       S_MIN < -(2**(WIDTH-1)) || S_MIN > 0 ||
       S_MAX < 0 || S_MAX > (2**(WIDTH-1)) - 1 ||
       S_MIN >= S_MAX) begin : g_bad_params
      $fatal(1, "ranged_dual_counter: illegal WIDTH/U_MAX/S_MIN/S_MAX combination");
   end

   localparam logic        [WIDTH-1:0] U_HI  = WIDTH'(U_MAX);
   localparam logic signed [WIDTH-1:0] S_LO  = WIDTH'(S_MIN);
   localparam logic signed [WIDTH-1:0] S_HI  = WIDTH'(S_MAX);
   // Explicit WIDTH-wide signed one: a 1-bit signed literal would read as -1.
   localparam logic signed [WIDTH-1:0] S_ONE = WIDTH'(1);

   logic        [WIDTH-1:0] u_cnt, u_next;
   logic signed [WIDTH-1:0] s_cnt, s_next;
   logic signed [WIDTH-1:0] s_load;
   logic                    u_tc_next, s_tc_next;

   assign s_load = load_val;

   always_comb begin
      u_next    = u_cnt;
      s_next    = s_cnt;
      u_tc_next = 1'b0;
      s_tc_next = 1'b0;
      if (clear) begin
         u_next = '0;
         s_next = '0;
      end else if (load) begin
         u_next = (load_val > U_HI) ? U_HI : load_val;
         if (s_load < S_LO)      s_next = S_LO;
         else if (s_load > S_HI) s_next = S_HI;
         else                    s_next = s_load;
      end else if (en) begin
         if (up) begin
            if (u_cnt == U_HI) begin
               u_tc_next = 1'b1;
               u_next    = SATURATE ? U_HI : '0;
            end else begin
               u_next = u_cnt + 1'b1;
            end
            if (s_cnt == S_HI) begin
               s_tc_next = 1'b1;
               s_next    = SATURATE ? S_HI : S_LO;
            end else begin
               s_next = s_cnt + S_ONE;
            end
         end else begin
            if (u_cnt == '0) begin
               u_tc_next = 1'b1;
               u_next    = SATURATE ? '0 : U_HI;
            end else begin
               u_next = u_cnt - 1'b1;
            end
            if (s_cnt == S_LO) begin
               s_tc_next = 1'b1;
               s_next    = SATURATE ? S_LO : S_HI;
            end else begin
               s_next = s_cnt - S_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         u_cnt <= '0;
         s_cnt <= '0;
         u_tc  <= 1'b0;
         s_tc  <= 1'b0;
      end else begin
         u_cnt <= u_next;
         s_cnt <= s_next;
         u_tc  <= u_tc_next;
         s_tc  <= s_tc_next;
      end
   end

   assign u_count = u_cnt;
   assign s_count = s_cnt;

endmodule

// File: tb/tb_ranged_dual_counter.sv
// tb_ranged_dual_counter
//   Drives a wrapping instance (dut_w) and a saturating instance (dut_s) with
//   the same inputs. Stimulus tasks push the hand-computed expected outputs;
//   the monitor pops and compares them one clock after the stimulus edge, or
//   immediately after an asynchronous reset is asserted.
module tb_ranged_dual_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, up = 1'b0, clear = 1'b0, load = 1'b0;
   logic [4:0] load_val = '0;
   logic [4:0] u_count_w, s_count_w, u_count_s, s_count_s;
   logic       u_tc_w, s_tc_w, u_tc_s, s_tc_s;
   logic       sample_req = 1'b0;

   int checks = 0;
   int passes = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   ranged_dual_counter #(.WIDTH(5), .U_MAX(10), .S_MIN(-10), .S_MAX(10), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .u_count(u_count_w), .s_count(s_count_w),
      .u_tc(u_tc_w), .s_tc(s_tc_w)
   );

   ranged_dual_counter #(.WIDTH(5), .U_MAX(10), .S_MIN(-10), .S_MAX(10), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .u_count(u_count_s), .s_count(s_count_s),
      .u_tc(u_tc_s), .s_tc(s_tc_s)
   );

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic       sat;   // 0 = compare dut_w, 1 = compare dut_s
      logic [4:0] u;
      logic [4:0] s;
      logic       utc;
      logic       stc;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   task automatic push_exp(input bit sat, input int u, input int s,
                           input bit utc, input bit stc, input string nm);
      exp_t e;
      e.sat = sat;
      e.u   = 5'(u);
      e.s   = 5'(s);
      e.utc = utc;
      e.stc = stc;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: wakes on each clock edge or an explicit sample request.
   initial begin
      exp_t       e;
      string      nm;
      logic [4:0] au, as_;
      logic       autc, astc;
      forever begin
         @(posedge clk or sample_req);
         #1;
         while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.sat) begin
               au = u_count_s; as_ = s_count_s; autc = u_tc_s; astc = s_tc_s;
            end else begin
               au = u_count_w; as_ = s_count_w; autc = u_tc_w; astc = s_tc_w;
            end
            checks++;
            if (au === e.u && as_ === e.s && autc === e.utc && astc === e.stc) begin
               passes++;
            end else begin
               $display("FAIL %s: got u=%0d s=%0d u_tc=%b s_tc=%b, expected u=%0d s=%0d u_tc=%b s_tc=%b",
                        nm, au, $signed(as_), autc, astc, e.u, $signed(e.s), e.utc, e.stc);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit d_en, input bit d_up, input bit d_clear,
                        input bit d_load, input logic [4:0] d_val);
      @(negedge clk);
      en = d_en; up = d_up; clear = d_clear; load = d_load; load_val = d_val;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      en = 1'b0; up = 1'b0; clear = 1'b0; load = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int u_e, s_e;
      bit tc_e;

      // Reset state, checked while rst is still low.
      @(negedge clk);
      push_exp(0, 0, 0, 0, 0, "reset_w");
      push_exp(1, 0, 0, 0, 0, "reset_s");
      sample_req = ~sample_req;
      @(negedge clk);
      rst = 1'b1;

      // Count up 12 edges: u 1..10,0,1 ; s 1..10,-10,-9 ; tc on the wrap.
      for (int i = 1; i <= 12; i++) begin
         drive(1, 1, 0, 0, 5'd0);
         u_e  = (i <= 10) ? i : i - 11;
         s_e  = (i <= 10) ? i : ((i == 11) ? -10 : -9);
         tc_e = (i == 11);
         push_exp(0, u_e, s_e, tc_e, tc_e, $sformatf("up_wrap_%0d", i));
      end

      // Down 2 edges from reset: wrap instance u 10,9 ; saturating u 0,0.
      reset_pulse();
      drive(1, 0, 0, 0, 5'd0);
      push_exp(0, 10, -1, 1, 0, "down_w_1");
      push_exp(1, 0,  -1, 1, 0, "down_s_1");
      drive(1, 0, 0, 0, 5'd0);
      push_exp(0, 9,  -2, 0, 0, "down_w_2");
      push_exp(1, 0,  -2, 1, 0, "down_s_2");

      // Load 9 then up 3 edges.
      drive(0, 0, 0, 1, 5'd9);
      push_exp(0, 9, 9, 0, 0, "load9_w");
      push_exp(1, 9, 9, 0, 0, "load9_s");
      drive(1, 1, 0, 0, 5'd0);
      push_exp(0, 10, 10, 0, 0, "sat_up_w_1");
      push_exp(1, 10, 10, 0, 0, "sat_up_s_1");
      drive(1, 1, 0, 0, 5'd0);
      push_exp(0, 0, -10, 1, 1, "sat_up_w_2");
      push_exp(1, 10, 10, 1, 1, "sat_up_s_2");
      drive(1, 1, 0, 0, 5'd0);
      push_exp(0, 1, -9, 0, 0, "sat_up_w_3");
      push_exp(1, 10, 10, 1, 1, "sat_up_s_3");

      // Load clamping.
      drive(0, 0, 0, 1, 5'h0C);
      push_exp(0, 10, 10, 0, 0, "clamp_0c_w");
      push_exp(1, 10, 10, 0, 0, "clamp_0c_s");
      drive(0, 0, 0, 1, 5'h1F);
      push_exp(0, 10, -1, 0, 0, "clamp_1f_w");
      push_exp(1, 10, -1, 0, 0, "clamp_1f_s");

      // Signed lower bound: load -10, then step down.
      drive(0, 0, 0, 1, 5'h16);
      push_exp(0, 10, -10, 0, 0, "load_m10_w");
      push_exp(1, 10, -10, 0, 0, "load_m10_s");
      drive(1, 0, 0, 0, 5'd0);
      push_exp(0, 9, 10,  0, 1, "s_min_down_w");
      push_exp(1, 9, -10, 0, 1, "s_min_down_s");

      // clear beats load and en.
      drive(1, 1, 1, 1, 5'd5);
      push_exp(0, 0, 0, 0, 0, "clear_prio_w");
      push_exp(1, 0, 0, 0, 0, "clear_prio_s");

      // Count to 7, then assert rst between edges.
      for (int i = 1; i <= 7; i++) begin
         drive(1, 1, 0, 0, 5'd0);
         push_exp(0, i, i, 0, 0, $sformatf("to7_%0d", i));
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      push_exp(0, 0, 0, 0, 0, "async_rst_w");
      push_exp(1, 0, 0, 0, 0, "async_rst_s");
      sample_req = ~sample_req;
      @(negedge clk);
      en = 1'b0;
      rst = 1'b1;

      // Count to 4, then hold with en=0 for 5 edges.
      for (int i = 1; i <= 4; i++) begin
         drive(1, 1, 0, 0, 5'd0);
         push_exp(0, i, i, 0, 0, $sformatf("to4_w_%0d", i));
         push_exp(1, i, i, 0, 0, $sformatf("to4_s_%0d", i));
      end
      for (int i = 1; i <= 5; i++) begin
         drive(0, 1, 0, 0, 5'd0);
         push_exp(0, 4, 4, 0, 0, $sformatf("hold_w_%0d", i));
         push_exp(1, 4, 4, 0, 0, $sformatf("hold_s_%0d", i));
      end

      // Let the monitor drain; leftovers mean it never saw those outputs.
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
